sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, legal range 1..255; number of consecutive cycles a synchronized sensor level must differ from the current output before that output changes.
REQ-002 Parameter: TEMP_RESET, default 6'd24; temp value after reset, chosen so that temp[5:4]==2'b01 (neither heat nor cool demand).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 raw_sensors  input  4  asynchronous contact inputs: [0] front door, [1] rear door, [2] fire, [3] window.
REQ-006 temp_valid  input  1  single-cycle strobe; temp_in is valid in this cycle.
REQ-007 temp_in  input  6  unsigned raw temperature sample.
REQ-008 sensors  output  4  debounced sensor levels, registered.
REQ-009 temp  output  6  averaged temperature, registered.
REQ-010 sensor_change  output  1  one-cycle pulse, asserted when any sensors bit changes.
REQ-011 temp_update  output  1  one-cycle pulse, asserted when temp is reloaded.

Function
REQ-012 Each raw_sensors bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each channel SHALL own an 8-bit debounce counter: cleared when the synchronized bit equals sensors[i], otherwise incremented.
REQ-014 When a counter increments to DEBOUNCE_CYCLES, sensors[i] SHALL take the synchronized value and the counter SHALL clear in the same edge.
REQ-015 Latency: with the raw input held stable, sensors[i] SHALL update on edge DEBOUNCE_CYCLES+2, where edge 1 is the first edge that samples the new raw level.
REQ-016 A synchronized level that returns to sensors[i] before the count completes SHALL clear the counter; sensors[i] SHALL NOT change.
REQ-017 Channels SHALL be independent; simultaneous qualifying changes on several channels SHALL update them on the same edge.
REQ-018 sensor_change SHALL be high for exactly the cycle following any sensors update edge; it SHALL be a single pulse even if several bits change together.
REQ-019 Temperature path: 2-state FSM, IDLE (count 0, accumulator 0) and ACCUM (1..3 samples held).
  - 8-bit accumulator; 2-bit sample counter.
REQ-020 In IDLE with temp_valid: accumulator SHALL load temp_in, count SHALL become 1, and the FSM SHALL go to ACCUM.
REQ-021 In ACCUM with temp_valid and count<3: accumulator SHALL add temp_in and count SHALL increment.
REQ-022 In ACCUM with temp_valid and count==3 (fourth sample):
  - temp SHALL load (accumulator + temp_in) >> 2, truncated;
  - temp_update SHALL pulse for the cycle after that edge;
  - accumulator and count SHALL clear;
  - the FSM SHALL return to IDLE.
REQ-023 The 8-bit sum SHALL never overflow (max 4x63 = 252); no clamping is required.
REQ-024 Cycles without temp_valid SHALL leave the FSM, accumulator and count unchanged; there is no timeout.
REQ-025 temp SHALL hold its value between updates.
REQ-026 temp_in SHALL be ignored whenever temp_valid is low.

Reset
REQ-027 On any rising edge with rst high, the block SHALL set:
  - sensors=4'b0000, temp=TEMP_RESET, sensor_change=0, temp_update=0;
  - synchronizers, debounce counters, accumulator and count all 0;
  - FSM to IDLE.
REQ-028 Inputs sampled during the rst edge, including temp_valid, SHALL be discarded.
REQ-029 A reset in the middle of an accumulation SHALL discard the partial sum.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Bench SHALL cover: rst for 2 cycles -> sensors=0, temp=24, both pulses 0.
REQ-031 Bench SHALL cover: raw_sensors[0] 0->1, held -> sensors[0]=1 after edge 6, sensor_change high exactly one cycle; later 1->0 held -> sensors[0]=0 six edges after the change is first sampled.
REQ-032 Bench SHALL cover: raw_sensors[2] high for 3 cycles, then low -> sensors[2] stays 0, no sensor_change.
REQ-033 Bench SHALL cover: temp_valid with samples 10,11,12,13, idle gaps between them -> temp=11 after the fourth strobe edge, temp_update one cycle; no change after the first three samples.
REQ-034 Bench SHALL cover: two samples of 60, then rst, then 40,40,40,40 -> temp=24 after reset, then 40 after the fourth post-reset sample.
REQ-035 Bench SHALL cover: four samples of 63 plus raw_sensors=4'b1010 on the same edge -> temp=63; sensors=4'b1010 on one edge; a single sensor_change pulse.

Source files
------------

// File: rtl/sensor_conditioner_if.sv
// Bus between the sensor front end and its consumer: raw contacts and
// temperature strobes in, debounced levels, averaged temperature and pulses out.
interface sensor_conditioner_if;
    logic [3:0] raw_sensors;
    logic       temp_valid;
    logic [5:0] temp_in;
    logic [3:0] sensors;
    logic [5:0] temp;
    logic       sensor_change;
    logic       temp_update;

    modport master (
        output raw_sensors, temp_valid, temp_in,
        input  sensors, temp, sensor_change, temp_update
    );

    modport slave (
        input  raw_sensors, temp_valid, temp_in,
        output sensors, temp, sensor_change, temp_update
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Debounces four asynchronous contact inputs and averages temperature samples
// in groups of four; both paths publish registered values plus one-cycle pulses.
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [5:0] TEMP_RESET      = 6'd24
) (
    input  logic          clk,
    input  logic          rst,
    sensor_conditioner_if.slave bus
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] sensors_reg;
    logic [3:0] sensors_next;
    logic [3:0] upd;
    logic       sensor_change_reg;
    logic [7:0] cnt_reg  [4];
    logic [7:0] cnt_next [4];

    // Counter runs only while the synchronized level disagrees with the output;
    // the edge that reaches the limit flips the output and restarts the count.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [7:0] cnt_inc;
            logic       differs;
            assign cnt_inc          = cnt_reg[gi] + 8'd1;
            assign differs          = sync2_reg[gi] != sensors_reg[gi];
            assign upd[gi]          = differs && (cnt_inc == DB_LIMIT);
            assign cnt_next[gi]     = (!differs || upd[gi]) ? 8'd0 : cnt_inc;
            assign sensors_next[gi] = upd[gi] ? sync2_reg[gi] : sensors_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg         <= 4'b0000;
            sync2_reg         <= 4'b0000;
            sensors_reg       <= 4'b0000;
            sensor_change_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_reg[i] <= 8'd0;
            end
        end else begin
            sync1_reg         <= bus.raw_sensors;
            sync2_reg         <= sync1_reg;
            sensors_reg       <= sensors_next;
            sensor_change_reg <= |upd;
            for (int i = 0; i < 4; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t     state_reg;
    logic [7:0] acc_reg;
    logic [1:0] count_reg;
    logic [5:0] temp_reg;
    logic       temp_update_reg;
    logic [7:0] sum;

    // Four 6-bit samples peak at 252, so the 8-bit sum cannot wrap.
    assign sum = acc_reg + {2'b00, bus.temp_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            acc_reg         <= 8'd0;
            count_reg       <= 2'd0;
            temp_reg        <= TEMP_RESET;
            temp_update_reg <= 1'b0;
        end else begin
            temp_update_reg <= 1'b0;
            if (bus.temp_valid) begin
                case (state_reg)
                    IDLE: begin
                        acc_reg   <= {2'b00, bus.temp_in};
                        count_reg <= 2'd1;
                        state_reg <= ACCUM;
                    end
                    ACCUM: begin
                        if (count_reg == 2'd3) begin
                            temp_reg        <= sum[7:2];
                            temp_update_reg <= 1'b1;
                            acc_reg         <= 8'd0;
                            count_reg       <= 2'd0;
                            state_reg       <= IDLE;
                        end else begin
                            acc_reg   <= sum;
                            count_reg <= count_reg + 2'd1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.sensors       = sensors_reg;
    assign bus.sensor_change = sensor_change_reg;
    assign bus.temp          = temp_reg;
    assign bus.temp_update   = temp_update_reg;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4: debounce latency,
// glitch rejection, four-sample averaging and reset behaviour.
module tb_sensor_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .TEMP_RESET      (6'd24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [5:0] value);
        bus.temp_valid = 1'b1;
        bus.temp_in    = value;
        tick(1);
        bus.temp_valid = 1'b0;
        bus.temp_in    = 6'h3f;
    endtask

    initial begin
        bus.raw_sensors = 4'b0000;
        bus.temp_valid  = 1'b0;
        bus.temp_in     = 6'd0;

        // Reset for two cycles
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_sensors", {4'd0, bus.sensors}, 8'd0);
        check("rst_temp", {2'd0, bus.temp}, 8'd24);
        check("rst_sensor_change", {7'd0, bus.sensor_change}, 8'd0);
        check("rst_temp_update", {7'd0, bus.temp_update}, 8'd0);
        $display("reset: sensors=%b temp=%0d", bus.sensors, bus.temp);

        // Front door 0->1: update on edge 6
        bus.raw_sensors = 4'b0001;
        tick(5);
        check("door_rise_edge5", {4'd0, bus.sensors}, 8'd0);
        check("door_rise_edge5_chg", {7'd0, bus.sensor_change}, 8'd0);
        tick(1);
        check("door_rise_edge6", {4'd0, bus.sensors}, 8'd1);
        check("door_rise_chg", {7'd0, bus.sensor_change}, 8'd1);
        tick(1);
        check("door_rise_chg_end", {7'd0, bus.sensor_change}, 8'd0);
        $display("door rise: sensors=%b", bus.sensors);

        // Front door 1->0
        tick(3);
        bus.raw_sensors = 4'b0000;
        tick(5);
        check("door_fall_edge5", {4'd0, bus.sensors}, 8'd1);
        tick(1);
        check("door_fall_edge6", {4'd0, bus.sensors}, 8'd0);
        check("door_fall_chg", {7'd0, bus.sensor_change}, 8'd1);
        tick(1);
        check("door_fall_chg_end", {7'd0, bus.sensor_change}, 8'd0);
        $display("door fall: sensors=%b", bus.sensors);

        // Fire glitch of 3 cycles is rejected
        bus.raw_sensors = 4'b0100;
        tick(3);
        bus.raw_sensors = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            check("fire_glitch_sensors", {4'd0, bus.sensors}, 8'd0);
            check("fire_glitch_chg", {7'd0, bus.sensor_change}, 8'd0);
            tick(1);
        end
        $display("fire glitch: sensors=%b", bus.sensors);

        // Average of 10,11,12,13 with idle gaps = 46>>2 = 11
        sample(6'd10);
        tick(2);
        sample(6'd11);
        tick(3);
        sample(6'd12);
        tick(1);
        check("avg_partial_temp", {2'd0, bus.temp}, 8'd24);
        check("avg_partial_upd", {7'd0, bus.temp_update}, 8'd0);
        tick(2);
        sample(6'd13);
        check("avg_temp", {2'd0, bus.temp}, 8'd11);
        check("avg_upd", {7'd0, bus.temp_update}, 8'd1);
        tick(1);
        check("avg_upd_end", {7'd0, bus.temp_update}, 8'd0);
        check("avg_temp_hold", {2'd0, bus.temp}, 8'd11);
        $display("average: temp=%0d", bus.temp);

        // Partial sum discarded by reset; a strobe during reset is ignored
        sample(6'd60);
        sample(6'd60);
        rst = 1'b1;
        bus.temp_valid = 1'b1;
        bus.temp_in    = 6'd60;
        tick(2);
        rst = 1'b0;
        bus.temp_valid = 1'b0;
        check("midrst_temp", {2'd0, bus.temp}, 8'd24);
        sample(6'd40);
        sample(6'd40);
        sample(6'd40);
        check("midrst_3rd_temp", {2'd0, bus.temp}, 8'd24);
        check("midrst_3rd_upd", {7'd0, bus.temp_update}, 8'd0);
        sample(6'd40);
        check("midrst_temp40", {2'd0, bus.temp}, 8'd40);
        check("midrst_upd", {7'd0, bus.temp_update}, 8'd1);
        $display("mid reset: temp=%0d", bus.temp);

        // Max samples plus two channels changing together
        sample(6'd63);
        sample(6'd63);
        sample(6'd63);
        bus.raw_sensors = 4'b1010;
        sample(6'd63);
        check("max_temp", {2'd0, bus.temp}, 8'd63);
        check("max_upd", {7'd0, bus.temp_update}, 8'd1);
        tick(4);
        check("multi_edge5", {4'd0, bus.sensors}, 8'd0);
        check("multi_edge5_chg", {7'd0, bus.sensor_change}, 8'd0);
        tick(1);
        check("multi_edge6", {4'd0, bus.sensors}, 8'b1010);
        check("multi_chg", {7'd0, bus.sensor_change}, 8'd1);
        tick(1);
        check("multi_chg_end", {7'd0, bus.sensor_change}, 8'd0);
        check("multi_hold", {4'd0, bus.sensors}, 8'b1010);
        $display("multi: sensors=%b temp=%0d", bus.sensors, bus.temp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
